// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add multiply and
// restoring divide share one adder; start/busy/done handshake plus MTHI/MTLO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               is_div_q;
    logic               neg_q;
    logic               rneg_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   mq_q;

    logic               sgn_op;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               div_zero;

    logic [WIDTH:0]     left;
    logic [WIDTH:0]     addend;
    logic               cin;
    logic [WIDTH+1:0]   sum;
    logic               ge;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   mq_d;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic n);
        return n ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic n);
        return n ? (~x + (2*WIDTH)'(1)) : x;
    endfunction

    // Operand conditioning: op[0]=0 selects the signed variants
    assign sgn_op   = ~op[0];
    assign sa       = sgn_op & src_a[WIDTH-1];
    assign sb       = sgn_op & src_b[WIDTH-1];
    assign a_mag    = cond_neg(src_a, sa);
    assign b_mag    = cond_neg(src_b, sb);
    assign div_zero = is_div_q && (opnd_q == '0);

    // Shared adder: add multiplicand for mult, subtract divisor for div
    always_comb begin
        if (is_div_q) begin
            left   = {acc_q, mq_q[WIDTH-1]};
            addend = ~{1'b0, opnd_q};
            cin    = 1'b1;
        end else begin
            left   = {1'b0, acc_q};
            addend = mq_q[0] ? {1'b0, opnd_q} : '0;
            cin    = 1'b0;
        end
        sum = {1'b0, left} + {1'b0, addend} + (WIDTH+2)'(cin);
        ge  = sum[WIDTH+1];
        if (is_div_q) begin
            acc_d = ge ? sum[WIDTH-1:0] : left[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], ge};
        end else begin
            acc_d = sum[WIDTH:1];
            mq_d  = {sum[0], mq_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fix = cond_neg2({acc_q, mq_q}, neg_q);
        hi_d     = prod_fix[2*WIDTH-1:WIDTH];
        lo_d     = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (div_zero) begin
                // mq still holds |dividend|; re-signing recovers raw src_a
                hi_d = cond_neg(mq_q, rneg_q);
                lo_d = '1;
            end else begin
                hi_d = cond_neg(acc_q, rneg_q);
                lo_d = cond_neg(mq_q, neg_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start) begin
            is_div_q <= op[1];
            neg_q    <= sa ^ sb;
            rneg_q   <= sa;
            opnd_q   <= op[1] ? b_mag : a_mag;
            mq_q     <= op[1] ? a_mag : b_mag;
            acc_q    <= '0;
        end else if (state_q == S_RUN && !div_zero) begin
            acc_q <= acc_d;
            mq_q  <= mq_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        cnt_q   <= CNT_W'(WIDTH);
                        busy_q  <= 1'b1;
                    end else begin
                        if (mthi) hi_q <= src_a;
                        if (mtlo) lo_q <= src_a;
                    end
                end
                S_RUN: begin
                    if (div_zero) begin
                        state_q <= S_FIX;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    if (is_div_q) dbz_q <= div_zero;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         mthi  = 1'b0;
    logic         mtlo  = 1'b0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = m_dz;
        h  = '0;
        l  = '0;
        case (o)
            2'b00: begin
                q = sa * sb;
                h = q[63:32];
                l = q[31:0];
            end
            2'b01: begin
                up = {32'h0, a} * {32'h0, b};
                h  = up[63:32];
                l  = up[31:0];
            end
            default: begin
                if (b == '0) begin
                    h  = a;
                    l  = '1;
                    dz = 1'b1;
                end else if (o == 2'b10) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    h  = r[31:0];
                    l  = q[31:0];
                    dz = 1'b0;
                end else begin
                    h  = a % b;
                    l  = a / b;
                    dz = 1'b0;
                end
            end
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit inject, input bit mt_start, input bit b2b);
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic         edz;
        int           n;
        bit           seen;
        int           lat;
        if (b2b) begin
            chk("b2b_done_at_start", 64'(done), 64'(1));
            chk("b2b_idle_at_start", 64'(busy), 64'(0));
        end
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        model_op(o, a, b, eh, el, edz);
        op = o; src_a = a; src_b = b; start = 1'b1; mthi = mt_start; mtlo = mt_start;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("done_low_after_start", 64'(done), 64'(0));
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            if (inject && n == 3) begin
                start = 1'b1; op = ~o; src_a = ~a; src_b = b ^ 32'h5; mthi = 1'b1; mtlo = 1'b1;
            end
            @(posedge clk); #1;
            n++;
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            if (done) seen = 1'b1;
            else begin
                chk("hi_held", 64'(hi), 64'(m_hi));
                chk("lo_held", 64'(lo), 64'(m_lo));
                chk("busy_in_run", 64'(busy), 64'(1));
            end
        end
        lat = (o[1] && b == '0) ? 2 : W + 1;
        chk("done_seen", 64'(seen), 64'(1));
        chk("latency", 64'(n), 64'(lat));
        chk("hi_result", 64'(hi), 64'(eh));
        chk("lo_result", 64'(lo), 64'(el));
        chk("div_by_zero", 64'(div_by_zero), 64'(edz));
        chk("busy_clear", 64'(busy), 64'(0));
        m_hi = eh; m_lo = el; m_dz = edz;
    endtask

    task automatic do_mt(input bit h, input bit l, input logic [W-1:0] v);
        src_a = v; mthi = h; mtlo = l;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        if (h) m_hi = v;
        if (l) m_lo = v;
        chk("mt_hi", 64'(hi), 64'(m_hi));
        chk("mt_lo", 64'(lo), 64'(m_lo));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cnt;
        bit  b2b;
        logic [1:0] o;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_dbz", 64'(div_by_zero), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_mt(1'b1, 1'b0, 32'd1234);
        chk("mthi_1234", 64'(hi), 64'd1234);

        op = 2'b00; src_a = 32'd7; src_b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("busy_before_abort", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_hi", 64'(hi), 64'(0));
        chk("abort_lo", 64'(lo), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) cnt++;
        end
        chk("no_activity_after_abort", 64'(cnt), 64'(0));
        chk("hi_after_abort", 64'(hi), 64'(0));

        run_op(2'b00, -32'sd3, 32'sd5, 1'b0, 1'b0, 1'b0);
        chk("mult_m3x5_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_m3x5_lo", 64'(lo), 64'hFFFF_FFF1);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b1);
        chk("multu_hi", 64'(hi), 64'h1);
        chk("multu_lo", 64'(lo), 64'hFFFF_FFFE);
        run_op(2'b10, -32'sd7, 32'sd2, 1'b0, 1'b0, 1'b1);
        chk("div_m7_2_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_m7_2_hi", 64'(hi), 64'hFFFF_FFFF);
        run_op(2'b11, 32'd7, 32'd2, 1'b0, 1'b0, 1'b1);
        chk("divu_7_2_lo", 64'(lo), 64'h3);
        chk("divu_7_2_hi", 64'(hi), 64'h1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        chk("div_min_lo", 64'(lo), 64'h8000_0000);
        chk("div_min_hi", 64'(hi), 64'h0);
        run_op(2'b10, 32'd25, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("dz_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("dz_hi", 64'(hi), 64'd25);
        chk("dz_flag", 64'(div_by_zero), 64'(1));
        run_op(2'b00, 32'd6, 32'd6, 1'b0, 1'b0, 1'b1);
        chk("dz_sticky_over_mult", 64'(div_by_zero), 64'(1));
        run_op(2'b11, 32'd10, 32'd3, 1'b0, 1'b0, 1'b1);
        chk("dz_cleared", 64'(div_by_zero), 64'(0));
        chk("divu_10_3_lo", 64'(lo), 64'h3);

        run_op(2'b01, 32'h0001_2345, 32'h678, 1'b1, 1'b0, 1'b1);
        run_op(2'b00, 32'hDEAD, 32'd3, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        do_mt(1'b1, 1'b1, 32'hA5A5_A5A5);
        chk("mt_both_hi", 64'(hi), 64'hA5A5_A5A5);
        chk("mt_both_lo", 64'(lo), 64'hA5A5_A5A5);
        do_mt(1'b0, 1'b1, 32'h0BAD_F00D);

        b2b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            run_op(o, pick(), pick(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), b2b);
            b2b = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                do_mt($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
                b2b = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
